// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common-data-bus arbiter. Four result producers compete for one
//             broadcast bus. At most one requester is granted per cycle, and
//             its data/tag are registered onto the bus one cycle later. A
//             saturating counter tracks the cycles in which two or more
//             requesters were valid at once.
//  Revision : 1.0 - initial release
//
//  Configuration macro:
//    CDB_ARB_ROUND_ROBIN_EN - defined  : round-robin search starting at a
//                                        2-bit rotating pointer.
//                             undefined: fixed priority, requester 0 highest.
//
//  Ports:
//    clk          in   1         clock, rising edge
//    rst          in   1         synchronous active-high reset
//    pause        in   1         stall; freezes all state, blocks grants
//    req_valid    in   4         per-requester valid
//    req_data     in   4*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//    req_tag      in   4*TAG_W   requester i tag  at [i*TAG_W  +: TAG_W]
//    req_ready    out  4         combinational one-hot grant
//    bus_valid    out  1         registered broadcast valid
//    bus_data     out  DATA_W    registered broadcast data
//    bus_tag      out  TAG_W     registered broadcast tag
//    conflict_cnt out  16        saturating count of multi-request cycles
// ============================================================================
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause,
    input  logic [3:0]          req_valid,
    input  logic [4*DATA_W-1:0] req_data,
    input  logic [4*TAG_W-1:0]  req_tag,
    output logic [3:0]          req_ready,
    output logic                bus_valid,
    output logic [DATA_W-1:0]   bus_data,
    output logic [TAG_W-1:0]    bus_tag,
    output logic [15:0]         conflict_cnt
);

    localparam int          c_NUM_REQ = 4;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]        w_ptr;     // search start position
    logic              w_found;
    logic [1:0]        w_gidx;
    logic [1:0]        w_idx;
    logic              w_xfer;
    logic              w_multi;

    logic              r_bus_valid_q, w_bus_valid_d;
    logic [DATA_W-1:0] r_bus_data_q,  w_bus_data_d;
    logic [TAG_W-1:0]  r_bus_tag_q,   w_bus_tag_d;
    logic [15:0]       r_cnt_q,       w_cnt_d;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    logic [1:0]        r_ptr_q, w_ptr_d;
    assign w_ptr = r_ptr_q;
`else
    assign w_ptr = 2'd0;
`endif

    // First valid requester in the order ptr, ptr+1, ptr+2, ptr+3; the 2-bit
    // add wraps naturally modulo 4.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < c_NUM_REQ; k++) begin
            w_idx = w_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    assign w_xfer    = w_found & ~pause & ~rst;
    assign req_ready = w_xfer ? (4'b0001 << w_gidx) : 4'b0000;

    // Clearing the lowest set bit leaves something only if two or more set.
    assign w_multi = |(req_valid & (req_valid - 4'd1));

    always_comb begin
        w_bus_valid_d = r_bus_valid_q;
        w_bus_data_d  = r_bus_data_q;
        w_bus_tag_d   = r_bus_tag_q;
        w_cnt_d       = r_cnt_q;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        w_ptr_d       = r_ptr_q;
`endif
        if (rst) begin
            w_bus_valid_d = 1'b0;
            w_bus_data_d  = '0;
            w_bus_tag_d   = '0;
            w_cnt_d       = '0;
`ifdef CDB_ARB_ROUND_ROBIN_EN
            w_ptr_d       = 2'd0;
`endif
        end else if (!pause) begin
            w_bus_valid_d = w_xfer;
            if (w_xfer) begin
                w_bus_data_d = req_data[int'(w_gidx)*DATA_W +: DATA_W];
                w_bus_tag_d  = req_tag[int'(w_gidx)*TAG_W +: TAG_W];
`ifdef CDB_ARB_ROUND_ROBIN_EN
                w_ptr_d      = w_gidx + 2'd1;
`endif
            end
            if (w_multi && (r_cnt_q != c_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_bus_valid_q <= w_bus_valid_d;
        r_bus_data_q  <= w_bus_data_d;
        r_bus_tag_q   <= w_bus_tag_d;
        r_cnt_q       <= w_cnt_d;
`ifdef CDB_ARB_ROUND_ROBIN_EN
        r_ptr_q       <= w_ptr_d;
`endif
    end

    assign bus_valid    = r_bus_valid_q;
    assign bus_data     = r_bus_data_q;
    assign bus_tag      = r_bus_tag_q;
    assign conflict_cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter, compared against a
//             behavioural model of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 3;

    logic                clk;
    logic                rst;
    logic                pause;
    logic [3:0]          req_valid;
    logic [4*DATA_W-1:0] req_data;
    logic [4*TAG_W-1:0]  req_tag;
    logic [3:0]          req_ready;
    logic                bus_valid;
    logic [DATA_W-1:0]   bus_data;
    logic [TAG_W-1:0]    bus_tag;
    logic [15:0]         conflict_cnt;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_tag      (req_tag),
        .req_ready    (req_ready),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .bus_tag      (bus_tag),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                m_ptr;
    bit                m_bv;
    logic [DATA_W-1:0] m_bd;
    logic [TAG_W-1:0]  m_bt;
    int                m_cnt;

    logic [3:0]        obs_ready;
    logic [3:0]        exp_ready;

`ifdef CDB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Which requester wins: walk the four positions starting from the
    // priority pointer (always 0 in fixed-priority mode). -1 means nobody.
    function automatic int model_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Apply one cycle of stimulus, record the combinational ready before the
    // edge, then advance the model across the edge.
    task automatic step(input logic [3:0] v, input logic p, input logic r);
        int w;
        req_valid = v;
        pause     = p;
        rst       = r;
        #1;
        obs_ready = req_ready;
        w = model_winner(v);
        exp_ready = (r || p || w < 0) ? 4'b0000 : 4'(1 << w);
        @(posedge clk);
        if (r) begin
            m_bv = 0; m_bd = '0; m_bt = '0; m_cnt = 0; m_ptr = 0;
        end else if (!p) begin
            m_bv = (w >= 0);
            if (w >= 0) begin
                m_bd = req_data[w*DATA_W +: DATA_W];
                m_bt = req_tag[w*TAG_W +: TAG_W];
                if (RR) m_ptr = (w + 1) % 4;
            end
            if ($countones(v) >= 2 && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic randomize_payload();
        for (int i = 0; i < 4; i++) begin
            req_data[i*DATA_W +: DATA_W] = $urandom;
            req_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
        end
    endtask

    task automatic test_reset();
        randomize_payload();
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready: got %b want 0000", obs_ready);
        end
        checks++;
        if ({bus_valid, bus_data, bus_tag, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h t=%0d c=%0d want all zero",
                     bus_valid, bus_data, bus_tag, conflict_cnt);
        end
    endtask

    task automatic test_single();
        step(4'b0000, 1'b0, 1'b1);
        req_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
        req_tag[2*TAG_W +: TAG_W]    = 3'd5;
        step(4'b0100, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b want 0100", obs_ready);
        end
        checks++;
        if ({bus_valid, bus_data, bus_tag} !== {1'b1, 32'hDEADBEEF, 3'd5}) begin
            errors++;
            $display("FAIL single_bus: got v=%b d=%h t=%0d want v=1 d=deadbeef t=5",
                     bus_valid, bus_data, bus_tag);
        end
    endtask

    task automatic test_all_valid();
        logic [3:0] want;
        step(4'b0000, 1'b0, 1'b1);
        randomize_payload();
        for (int c = 0; c < 4; c++) begin
            want = RR ? 4'(1 << c) : 4'b0001;
            step(4'b1111, 1'b0, 1'b0);
            checks++;
            if (obs_ready !== want) begin
                errors++; $display("FAIL all_valid_grant%0d: got %b want %b", c, obs_ready, want);
            end
            checks++;
            if (bus_data !== req_data[(RR ? c : 0)*DATA_W +: DATA_W]) begin
                errors++; $display("FAIL all_valid_data%0d: got %h want %h", c, bus_data,
                                   req_data[(RR ? c : 0)*DATA_W +: DATA_W]);
            end
        end
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++; $display("FAIL all_valid_cnt: got %0d want 4", conflict_cnt);
        end
    endtask

    task automatic test_starve();
        logic [3:0] want;
        step(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            // Round-robin alternates 1,3,1; fixed priority always picks 1.
            want = (RR && c == 1) ? 4'b1000 : 4'b0010;
            step(4'b1010, 1'b0, 1'b0);
            checks++;
            if (obs_ready !== want) begin
                errors++; $display("FAIL starve_grant%0d: got %b want %b", c, obs_ready, want);
            end
        end
    endtask

    task automatic test_pause();
        logic [15:0] cnt_before;
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        req_tag[0 +: TAG_W] = 3'd2;
        req_data[0 +: DATA_W] = 32'h0000_1234;
        step(4'b0001, 1'b0, 1'b1);   // clears pointer so requester 0 wins next
        step(4'b0001, 1'b0, 1'b0);
        cnt_before = conflict_cnt;
        checks++;
        if ({bus_valid, bus_tag} !== {1'b1, 3'd2}) begin
            errors++; $display("FAIL pause_setup: got v=%b t=%0d want v=1 t=2", bus_valid, bus_tag);
        end
        for (int c = 0; c < 3; c++) begin
            req_data[0 +: DATA_W] = $urandom;
            step(4'b0001, 1'b1, 1'b0);
            checks++;
            if (obs_ready !== 4'b0000) begin
                errors++; $display("FAIL pause_ready%0d: got %b want 0000", c, obs_ready);
            end
            checks++;
            if ({bus_valid, bus_data, bus_tag, conflict_cnt} !==
                {1'b1, 32'h0000_1234, 3'd2, cnt_before}) begin
                errors++;
                $display("FAIL pause_hold%0d: got v=%b d=%h t=%0d c=%0d want v=1 d=00001234 t=2 c=%0d",
                         c, bus_valid, bus_data, bus_tag, conflict_cnt, cnt_before);
            end
        end
        step(4'b0001, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 4'b0001 || bus_valid !== 1'b1 || bus_data !== req_data[0 +: DATA_W]) begin
            errors++;
            $display("FAIL pause_resume: got ready=%b v=%b d=%h want ready=0001 v=1 d=%h",
                     obs_ready, bus_valid, bus_data, req_data[0 +: DATA_W]);
        end
    endtask

    task automatic test_reset_grant();
        step(4'b0000, 1'b0, 1'b1);
        randomize_payload();
        step(4'b1111, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b1);
        checks++;
        if (obs_ready !== 4'b0000) begin
            errors++; $display("FAIL rstgrant_ready: got %b want 0000", obs_ready);
        end
        checks++;
        if ({bus_valid, bus_data, conflict_cnt} !== '0) begin
            errors++; $display("FAIL rstgrant_state: got v=%b d=%h c=%0d want zeros",
                               bus_valid, bus_data, conflict_cnt);
        end
        step(4'b1111, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++; $display("FAIL rstgrant_ptr: got %b want 0001", obs_ready);
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        logic       p, r;
        for (int c = 0; c < 400; c++) begin
            randomize_payload();
            v = 4'($urandom);
            p = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 40) == 0);
            step(v, p, r);
            checks++;
            if (obs_ready !== exp_ready) begin
                errors++; $display("FAIL random_ready%0d: got %b want %b", c, obs_ready, exp_ready);
            end
            checks++;
            if ({bus_valid, bus_data, bus_tag, conflict_cnt} !== {m_bv, m_bd, m_bt, 16'(m_cnt)}) begin
                errors++;
                $display("FAIL random_bus%0d: got v=%b d=%h t=%0d c=%0d want v=%b d=%h t=%0d c=%0d",
                         c, bus_valid, bus_data, bus_tag, conflict_cnt, m_bv, m_bd, m_bt, m_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        step(4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 65535; c++) step(4'b0011, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_reach: got %h want ffff", conflict_cnt);
        end
        step(4'b1100, 1'b0, 1'b0);
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; req_valid = '0; req_data = '0; req_tag = '0;
        m_ptr = 0; m_bv = 0; m_bd = '0; m_bt = '0; m_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_valid();
        test_starve();
        test_pause();
        test_reset_grant();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
